// File: rtl/bidir_bus_arbiter_if.sv
// bidir_bus_arbiter_if: request, grant and buffer-control signals between the arbiter and its two bus sides
interface bidir_bus_arbiter_if;
   logic REQ_A;
   logic REQ_B;
   logic CE;
   logic SR;
   logic GNT_A;
   logic GNT_B;
   logic BUSY;
   modport master (output REQ_A, REQ_B, input CE, SR, GNT_A, GNT_B, BUSY);
   modport slave (input REQ_A, REQ_B, output CE, SR, GNT_A, GNT_B, BUSY);
endinterface

// File: rtl/bidir_bus_arbiter.sv
// bidir_bus_arbiter: round-robin owner of an 8-bit bidirectional buffer with dead-cycle turnaround and burst preemption
module bidir_bus_arbiter #(
   parameter int TURNAROUND = 1,
   parameter int MAX_BURST  = 4
) (
   input logic CLK,
   input logic RST_N,
   bidir_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XFER_AB, XFER_BA, TURN} state_t;
   state_t r_state;
   state_t w_nxt;
   state_t w_win;
   logic [3:0] r_beat;
   logic [3:0] r_turn;
   logic [3:0] w_beat_nxt;
   logic [3:0] w_turn_nxt;
   logic r_fresh;
   logic r_ce;
   logic r_sr;
   logic r_gnt_a;
   logic r_gnt_b;
   logic r_busy;
   logic w_any;
   logic w_pick_a;
   logic w_own;
   logic w_oth;
   logic w_beat_end;
   logic w_xfer_nxt;
   // SR doubles as the round-robin pointer: it always names the side last served (B out of reset)
   always_comb begin
      w_any      = bus.REQ_A | bus.REQ_B;
      w_pick_a   = (bus.REQ_A & bus.REQ_B) ? ~r_sr : bus.REQ_A;
      w_win      = w_pick_a ? XFER_AB : XFER_BA;
      w_own      = (r_state == XFER_AB) ? bus.REQ_A : bus.REQ_B;
      w_oth      = (r_state == XFER_AB) ? bus.REQ_B : bus.REQ_A;
      w_beat_end = r_beat == 4'(MAX_BURST - 1);
      w_nxt      = r_state;
      case (r_state)
         IDLE:    w_nxt = !w_any ? IDLE : (r_fresh || w_pick_a == r_sr) ? w_win : TURN;
         TURN:    w_nxt = (r_turn != 4'd0) ? TURN : w_any ? w_win : IDLE;
         default: w_nxt = !w_own ? (w_oth ? TURN : IDLE) : (w_beat_end && w_oth) ? TURN : r_state;
      endcase
      w_xfer_nxt = (w_nxt == XFER_AB) || (w_nxt == XFER_BA);
      w_beat_nxt = (w_nxt == r_state && w_xfer_nxt && !w_beat_end) ? r_beat + 4'd1 : 4'd0;
      w_turn_nxt = (r_state != TURN) ? 4'(TURNAROUND - 1) : (r_turn != 4'd0) ? r_turn - 4'd1 : 4'd0;
   end
   // State, counters and all bus outputs registered together; reset drops CE and grants without a clock
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_beat  <= 4'd0;
         r_turn  <= 4'd0;
         r_fresh <= 1'b1;
         r_ce    <= 1'b0;
         r_sr    <= 1'b0;
         r_gnt_a <= 1'b0;
         r_gnt_b <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_beat  <= w_beat_nxt;
         r_turn  <= w_turn_nxt;
         r_fresh <= r_fresh & ~w_xfer_nxt;
         r_ce    <= w_xfer_nxt;
         r_sr    <= w_xfer_nxt ? (w_nxt == XFER_AB) : r_sr;
         r_gnt_a <= w_nxt == XFER_AB;
         r_gnt_b <= w_nxt == XFER_BA;
         r_busy  <= w_nxt != IDLE;
      end
   end
   assign bus.CE    = r_ce;
   assign bus.SR    = r_sr;
   assign bus.GNT_A = r_gnt_a;
   assign bus.GNT_B = r_gnt_b;
   assign bus.BUSY  = r_busy;
endmodule

// File: tb/tb_bidir_bus_arbiter.sv
// tb_bidir_bus_arbiter: scoreboard bench for two arbiter configurations driven by the same request stream
module tb_bidir_bus_arbiter;
   typedef struct {
      int mode;
      int dead;
      int beats;
      bit fresh;
      bit last_a;
      bit sr;
   } mdl_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_a = 1'b0;
   logic req_b = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [4:0] q1[$];
   logic [4:0] q3[$];
   logic [4:0] out1;
   logic [4:0] out3;
   logic [4:0] p1 = 5'd0;
   logic [4:0] p3 = 5'd0;
   mdl_t m1;
   mdl_t m3;
   always #5 clk = ~clk;
   bidir_bus_arbiter_if ifa ();
   bidir_bus_arbiter_if ifb ();
   assign ifa.REQ_A = req_a;
   assign ifa.REQ_B = req_b;
   assign ifb.REQ_A = req_a;
   assign ifb.REQ_B = req_b;
   assign out1 = {ifa.CE, ifa.SR, ifa.GNT_A, ifa.GNT_B, ifa.BUSY};
   assign out3 = {ifb.CE, ifb.SR, ifb.GNT_A, ifb.GNT_B, ifb.BUSY};
   bidir_bus_arbiter u1 (.CLK(clk), .RST_N(rst_n), .bus(ifa));
   bidir_bus_arbiter #(.TURNAROUND(3), .MAX_BURST(2)) u3 (.CLK(clk), .RST_N(rst_n), .bus(ifb));
   // mode: 0 idle, 1 A owns bus, 2 B owns bus, 3 dead turnaround
   function automatic mdl_t mreset();
      mdl_t m;
      m.mode = 0; m.dead = 0; m.beats = 0; m.fresh = 1'b1; m.last_a = 1'b0; m.sr = 1'b0;
      return m;
   endfunction
   function automatic mdl_t grant(mdl_t m, bit to_a);
      m.mode = to_a ? 1 : 2; m.beats = 0; m.last_a = to_a; m.sr = to_a; m.fresh = 1'b0;
      return m;
   endfunction
   function automatic mdl_t step(mdl_t m, bit a, bit b, int ta, int mb);
      bit pick_a = (a && b) ? !m.last_a : a;
      bit own = (m.mode == 1) ? a : b;
      bit oth = (m.mode == 1) ? b : a;
      if (m.mode == 0) begin
         if (!(a || b)) return m;
         if (m.fresh || pick_a == m.last_a) return grant(m, pick_a);
         m.mode = 3; m.dead = ta;
         return m;
      end
      if (m.mode == 3) begin
         if (m.dead > 1) begin m.dead--; return m; end
         if (!(a || b)) begin m.mode = 0; return m; end
         return grant(m, pick_a);
      end
      m.beats++;
      if (!own || (m.beats == mb && oth)) begin
         m.mode = oth ? 3 : 0; m.dead = ta;
         return m;
      end
      if (m.beats == mb) m.beats = 0;
      return m;
   endfunction
   function automatic logic [4:0] mexp(mdl_t m);
      return {m.mode == 1 || m.mode == 2, m.sr, m.mode == 1, m.mode == 2, m.mode != 0};
   endfunction
   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask
   task automatic mon(input string nm, input logic [4:0] got, input logic [4:0] exp, input logic [4:0] prev);
      check({nm, " outputs"}, 64'(got), 64'(exp));
      check({nm, " gnt_excl"}, 64'({got[2] & got[1], got[2] | got[1]}), 64'({1'b0, got[4]}));
      if (prev[4] && got[4]) check({nm, " sr_stable"}, 64'(got[3]), 64'(prev[3]));
   endtask
   task automatic drive(input bit a, input bit b, input int n);
      req_a = a;
      req_b = b;
      repeat (n) @(negedge clk);
   endtask
   initial begin
      m1 = mreset();
      m3 = mreset();
   end
   // reference model advances on each rising edge and queues the outputs it expects
   always @(posedge clk) begin
      m1 = !rst_n ? mreset() : step(m1, req_a, req_b, 1, 4);
      m3 = !rst_n ? mreset() : step(m3, req_a, req_b, 3, 2);
      q1.push_back(mexp(m1));
      q3.push_back(mexp(m3));
   end
   // monitor samples just after each edge and retires one expectation per instance
   always @(posedge clk) begin
      #1;
      if (q1.size() == 0) check("u1 queue_empty", 64'd1, 64'd0);
      else mon("u1", out1, q1.pop_front(), p1);
      if (q3.size() == 0) check("u3 queue_empty", 64'd1, 64'd0);
      else mon("u3", out3, q3.pop_front(), p3);
      p1 = out1;
      p3 = out3;
   end
   initial begin
      logic [39:0] gp;
      logic [39:0] ep;
      logic [11:0] tg;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 6);
      drive(1, 1, 24);
      drive(0, 1, 8);
      drive(1, 0, 3);
      drive(0, 0, 3);
      rst_n = 1'b0;
      req_a = 1'b1;
      req_b = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         gp[2*i +: 2] = {ifa.GNT_A, ifa.GNT_B};
         ep[2*i +: 2] = (i % 10 < 4) ? 2'b10 : (i % 10 == 4 || i % 10 == 9) ? 2'b00 : 2'b01;
      end
      check("u1 rr_pattern", 64'(gp), 64'(ep));
      drive(0, 0, 3);
      drive(0, 1, 8);
      drive(0, 0, 2);
      req_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tg[3*i +: 3] = {ifb.BUSY, ifb.CE, ifb.GNT_A};
      end
      check("u3 turn3_then_a", 64'(tg), 64'(12'b111_100_100_100));
      drive(0, 1, 4);
      check("u1 gnt_b_before_rst", 64'(ifa.GNT_B), 64'd1);
      #2 rst_n = 1'b0;
      #1 check("u1 async_drop", 64'({ifa.CE, ifa.GNT_B, ifa.BUSY}), 64'd0);
      @(negedge clk);
      req_a = 1'b1;
      req_b = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2 check("u1 first_gnt_a", 64'({ifa.CE, ifa.SR, ifa.GNT_A}), 64'(3'b111));
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 249) != 0);
         if ($urandom_range(0, 3) == 0) req_a = ~req_a;
         if ($urandom_range(0, 3) == 0) req_b = ~req_b;
      end
      rst_n = 1'b1;
      drive(0, 0, 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
